// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART serial transmitter (start, 8 data bits MSB first, stop) with a
// one-entry holding register; defining UART_TX_PARITY_EN adds an even-parity bit.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT_FAST = 10417,
    parameter int CLKS_PER_BIT_SLOW = 20834
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       baud_sel,
    output logic       out,
    output logic       busy,
    output logic       frame_done
);
    localparam int MAX_CLKS = (CLKS_PER_BIT_FAST > CLKS_PER_BIT_SLOW) ?
                              CLKS_PER_BIT_FAST : CLKS_PER_BIT_SLOW;
    localparam int CNT_W = $clog2(MAX_CLKS);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(CLKS_PER_BIT_FAST - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(CLKS_PER_BIT_SLOW - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    function automatic logic [CNT_W-1:0] last_count(input logic div);
        if (div) begin
            return SLOW_LAST;
        end else begin
            return FAST_LAST;
        end
    endfunction

    state_t           state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r, cnt_d_s;
    logic [2:0]       bit_r, bit_d_s;
    logic [7:0]       shift_r, shift_d_s;
    logic             div_r, div_d_s;
    logic [7:0]       hold_r;
    logic             hold_full_r;
    logic             tx_ready_r;
    logic             out_r, out_d_s;
    logic             busy_r, busy_d_s;
    logic             done_r, done_d_s;
    logic             load_s;
    logic             accept_s;
    logic             bit_last_s;
`ifdef UART_TX_PARITY_EN
    logic             parity_r, parity_d_s;
`endif

    assign accept_s   = tx_valid && tx_ready_r;
    assign bit_last_s = (cnt_r == last_count(div_r));

    // Holding register: filled by a transfer, emptied when a frame takes the byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r      <= 8'h00;
            hold_full_r <= 1'b0;
            tx_ready_r  <= 1'b1;
        end else if (accept_s) begin
            hold_r      <= tx_data;
            hold_full_r <= 1'b1;
            tx_ready_r  <= 1'b0;
        end else if (load_s) begin
            hold_full_r <= 1'b0;
            tx_ready_r  <= 1'b1;
        end else begin
            hold_full_r <= hold_full_r;
            tx_ready_r  <= tx_ready_r;
        end
    end

    // State and datapath registers; outputs are registered from next-cycle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            bit_r    <= 3'd0;
            shift_r  <= 8'h00;
            div_r    <= 1'b0;
            out_r    <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r  <= next_state_s;
            cnt_r    <= cnt_d_s;
            bit_r    <= bit_d_s;
            shift_r  <= shift_d_s;
            div_r    <= div_d_s;
            out_r    <= out_d_s;
            busy_r   <= busy_d_s;
            done_r   <= done_d_s;
`ifdef UART_TX_PARITY_EN
            parity_r <= parity_d_s;
`endif
        end
    end

    // Next-state logic; load_s marks the cycle a frame takes the held byte.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (hold_full_r) begin
                    next_state_s = START;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: begin
                if (bit_last_s) begin
                    next_state_s = DATA;
                end else begin
                    next_state_s = START;
                end
            end
            DATA: begin
                if (bit_last_s && (bit_r == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    next_state_s = PARITY;
`else
                    next_state_s = STOP;
`endif
                end else begin
                    next_state_s = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_last_s) begin
                    next_state_s = STOP;
                end else begin
                    next_state_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (bit_last_s && hold_full_r) begin
                    next_state_s = START;
                    load_s       = 1'b1;
                end else if (bit_last_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = STOP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Bit timer, bit counter, shift register and divider select.
    always_comb begin
        cnt_d_s   = cnt_r;
        bit_d_s   = bit_r;
        shift_d_s = shift_r;
        div_d_s   = div_r;
        if (load_s) begin
            cnt_d_s   = '0;
            bit_d_s   = 3'd0;
            shift_d_s = hold_r;
            div_d_s   = baud_sel;
        end else if (state_r == IDLE) begin
            cnt_d_s = '0;
        end else if (bit_last_s) begin
            cnt_d_s = '0;
            if (state_r == DATA) begin
                shift_d_s = {shift_r[6:0], 1'b0};
                bit_d_s   = bit_r + 3'd1;
            end else begin
                shift_d_s = shift_r;
            end
        end else begin
            cnt_d_s = cnt_r + CNT_W'(1);
        end
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
`ifdef UART_TX_PARITY_EN
        parity_d_s = load_s ? even_parity(hold_r) : parity_r;
`endif
        busy_d_s = (next_state_s != IDLE);
        done_d_s = (next_state_s == STOP) && (cnt_d_s == last_count(div_d_s));
        case (next_state_s)
            IDLE:    out_d_s = 1'b1;
            START:   out_d_s = 1'b0;
            DATA:    out_d_s = shift_d_s[7];
`ifdef UART_TX_PARITY_EN
            PARITY:  out_d_s = parity_d_s;
`endif
            STOP:    out_d_s = 1'b1;
            default: out_d_s = 1'b1;
        endcase
    end

    assign tx_ready   = tx_ready_r;
    assign out        = out_r;
    assign busy       = busy_r;
    assign frame_done = done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame with FAST=4, SLOW=8; follows UART_TX_PARITY_EN if defined.
module tb_uart_tx_frame;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FAST = 4;
    localparam int SLOW = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       baud_sel = 1'b0;
    logic       out;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    uart_tx_frame #(.CLKS_PER_BIT_FAST(FAST), .CLKS_PER_BIT_SLOW(SLOW)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .baud_sel(baud_sel), .out(out), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of bit values, each held for N cycles.
    typedef struct packed { logic o; logic b; logic d; } rec_t;
    localparam rec_t IDLE_REC = '{o: 1'b1, b: 1'b0, d: 1'b0};
    rec_t       frame_q[$];
    logic [7:0] hold_q[$];
    rec_t       cur = IDLE_REC;
    logic       m_ready = 1'b1;

    task automatic build_frame(input logic [7:0] d, input logic bsel);
        logic bits[$];
        int n;
        n = bsel ? SLOW : FAST;
        bits.push_back(1'b0);
        for (int i = 7; i >= 0; i--) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        for (int i = 0; i < bits.size(); i++)
            for (int c = 0; c < n; c++)
                frame_q.push_back('{o: bits[i], b: 1'b1,
                                    d: (i == bits.size() - 1) && (c == n - 1)});
    endtask

    initial begin
        logic xfer;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                frame_q.delete();
                hold_q.delete();
                cur     = IDLE_REC;
                m_ready = 1'b1;
            end else begin
                xfer = tx_valid && m_ready;
                if (frame_q.size() == 0 && hold_q.size() != 0)
                    build_frame(hold_q.pop_front(), baud_sel);
                if (frame_q.size() != 0) cur = frame_q.pop_front();
                else cur = IDLE_REC;
                if (xfer) hold_q.push_back(tx_data);
                m_ready = (hold_q.size() == 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("model_out", {31'd0, out}, {31'd0, cur.o});
                check("model_busy", {31'd0, busy}, {31'd0, cur.b});
                check("model_frame_done", {31'd0, frame_done}, {31'd0, cur.d});
                check("model_tx_ready", {31'd0, tx_ready}, {31'd0, m_ready});
            end
        end
    end

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [7:0] d, input logic bsel);
        int guard;
        logic rdy;
        guard = 0;
        tx_data = d; tx_valid = 1'b1; baud_sel = bsel;
        rdy = tx_ready;
        while (!rdy && guard < 400) begin
            @(negedge clk);
            rdy = tx_ready;
            guard++;
        end
        if (rdy) begin
            @(posedge clk);
            @(negedge clk);
        end else begin
            errors++;
            $display("FAIL send_timeout: tx_ready stayed 0 expected 1");
        end
        tx_valid = 1'b0;
    endtask

    task automatic capture(input int n, output int len, output int dones, output logic [31:0] bits);
        int guard;
        len = 0; dones = 0; bits = 32'd0; guard = 0;
        while (busy !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL capture_timeout: busy stayed 0 expected 1");
        end else begin
            while (busy === 1'b1 && len < 400) begin
                if (len % n == n / 2) bits = {bits[30:0], out};
                if (frame_done === 1'b1) dones++;
                len++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int len, dones;
        logic [31:0] bits, exp_a1, exp_8a, exp_00;
`ifdef UART_TX_PARITY_EN
        exp_a1 = 32'b01010000111;
        exp_8a = 32'b01000101011;
        exp_00 = 32'b00000000001;
`else
        exp_a1 = 32'b0101000011;
        exp_8a = 32'b0100010101;
        exp_00 = 32'b0000000001;
`endif
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", {31'd0, out}, 32'd1);
        check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);

        send(8'hA1, 1'b0);
        capture(FAST, len, dones, bits);
        check("a1_bits", bits, exp_a1);
        check("a1_len", len, NBITS * FAST);
        check("a1_done_count", dones, 32'd1);
        repeat (3) @(negedge clk);

        send(8'h8A, 1'b1);
        capture(SLOW, len, dones, bits);
        check("8a_bits", bits, exp_8a);
        check("8a_len", len, NBITS * SLOW);
        check("8a_done_count", dones, 32'd1);
        repeat (3) @(negedge clk);

        send(8'h00, 1'b0);
        capture(FAST, len, dones, bits);
        check("00_bits", bits, exp_00);
        check("00_len", len, NBITS * FAST);
        repeat (3) @(negedge clk);

        fork
            begin
                send(8'h55, 1'b0);
                send(8'hAA, 1'b0);
                check("b2b_ready_low", {31'd0, tx_ready}, 32'd0);
            end
            capture(FAST, len, dones, bits);
        join
        check("b2b_len", len, 2 * NBITS * FAST);
        check("b2b_done_count", dones, 32'd2);
        repeat (3) @(negedge clk);

        send(8'h3C, 1'b0);
        fork
            capture(FAST, len, dones, bits);
            begin
                repeat (15) @(negedge clk);
                baud_sel = 1'b1;
            end
        join
        check("baud_toggle_len", len, NBITS * FAST);
        baud_sel = 1'b0;
        repeat (3) @(negedge clk);

        send(8'hA1, 1'b0);
        send(8'h5A, 1'b0);
        repeat (16) @(negedge clk);
        check("pre_reset_out_bit3", {31'd0, out}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_out", {31'd0, out}, 32'd1);
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        check("mid_reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) dones++;
        end
        check("post_reset_no_done", dones, 32'd0);

        send(8'h00, 1'b0);
        capture(FAST, len, dones, bits);
        check("recover_bits", bits, exp_00);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART serial transmitter: the transmit-side counterpart of the system's serial receive path on `in`. It serializes one byte per frame on `out`. The frame is start bit 0, eight data bits MSB first, an optional even-parity bit, then stop bit 1; the line idles high. It sits between the command/status logic and the board TX pin, and is paced by the same 9600/4800 baud selection the receiver uses. A one-entry holding register lets the next byte be queued while the current frame shifts out.

## Interface
- `CLKS_PER_BIT_FAST`, default 10417: clock cycles per bit at 9600 baud with a 100 MHz clock. Must be ≥ 2.
- `CLKS_PER_BIT_SLOW`, default 20834: clock cycles per bit at 4800 baud. Must be ≥ 2.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `tx_data` input 8: byte to send.
- `tx_valid` input 1: byte on `tx_data` is offered.
- `tx_ready` output 1: the holding register is empty. A transfer occurs on a cycle where `tx_valid && tx_ready`.
- `baud_sel` input 1: 0 selects FAST, 1 selects SLOW. Sampled at frame start only.
- `out` output 1: serial line.
- `busy` output 1: a frame is in progress (state ≠ IDLE).
- `frame_done` output 1: one-cycle pulse at the end of the stop bit.

## Operation
- Reset values: `out`=1, `tx_ready`=1, `busy`=0, `frame_done`=0. State is IDLE, counters are 0, and the holding register is empty.
- Holding register: loaded on a transfer, and `tx_ready` drops the next cycle. It empties when the FSM takes the byte at frame start.
- FSM states are IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: if the holding register is full, copy the byte to the shift register and latch `baud_sel` into `div_q`, then go to START.
  - START: `out`=0 for one bit time.
  - DATA: `out`=`shift[7]`, shifting left each bit time. The bit counter runs 0..7, and on the end of bit 7 the FSM advances.
  - PARITY: `out`=^byte (even parity, so total ones including parity are even). Lasts one bit time.
  - STOP: `out`=1 for one bit time. At its last cycle, pulse `frame_done`. If the holding register is full, go directly to START and reload (back-to-back frames, no idle gap); otherwise go to IDLE.
- Bit timer: counts 0..N-1, where N is the CLKS_PER_BIT selected by `div_q`. Each state ends when the count reaches N-1. The timer width is $clog2 of the larger parameter.
- A `baud_sel` change mid-frame has no effect until the next frame start.
- `tx_valid` while `tx_ready`=0 is ignored. Upstream must hold the byte until a transfer occurs.
- `out` is registered, so there are no glitches.

## Timing
- A transfer in IDLE at edge k loads the holding register. The FSM enters START at edge k+1, and `out` falls after edge k+1.
- Frame length: 11·N cycles with parity, 10·N without.
- The `frame_done` pulse coincides with the last cycle of STOP.
- `tx_ready` returns to 1 the cycle after the FSM takes the byte. This lets a second byte be accepted during START of the current frame.
- Asynchronous reset mid-frame forces `out`=1 immediately and discards both the holding register and the shift register.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists and the frame is 11 bits (0, d7..d0, p, 1). This matches the receiver's 12-bit test frames, which include a leading idle 1.
- Macro undefined: the PARITY state and parity logic are removed. DATA goes straight to STOP and the frame is 10 bits.

## Test plan
- Bench parameters are FAST=4 and SLOW=8, with `UART_TX_PARITY_EN` defined.
- Reset: hold `rst_n`=0, then release. Require `out`=1, `tx_ready`=1, `busy`=0, and `frame_done` never pulsing.
- Single byte: send 0xA1 with `baud_sel`=0. Bits sampled mid-bit must be 0,1,0,1,0,0,0,0,1,1,1. The frame is 44 cycles, and `frame_done` fires once.
- SLOW and parity: send 0x8A with `baud_sel`=1. Require each bit to last 8 cycles, parity=1, and a total frame of 88 cycles. Send 0x00 and require parity=0.
- Back-to-back: queue 0x55 and then 0xAA, the second accepted during START of the first. Require no idle gap: STOP of frame 1 is immediately followed by the start bit of frame 2. Also require `tx_ready` to drop to 0 while the second byte is held.
- Mid-frame events: toggle `baud_sel` during DATA and require the current frame to keep its bit time. Assert `rst_n`=0 during bit 3, then require `out`=1 at once and no `frame_done` pulse.
- Build without the macro: send 0xA1 and require a 10-bit frame of 40 cycles with no parity bit.
